// File: rtl/mem_access_unit.sv
// Load/store initiator for the 16-bit synchronous data memory.
// 32-bit accesses are split into a low beat at A and a high beat at A+1.
module mem_access_unit #(
    parameter int ADDR_W = 21,
    parameter int MEM_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic                 req_wide,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [2*MEM_W-1:0]   req_wdata,
    output logic                 resp_valid,
    output logic [2*MEM_W-1:0]   resp_rdata,
    output logic [ADDR_W-1:0]    mem_dst_addr,
    output logic [MEM_W-1:0]     mem_wdata,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_src_addr,
    input  logic [MEM_W-1:0]     mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        RD_WAIT,
        RESP
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 wide_q;
    logic [MEM_W-1:0]     whi_q;
    logic [MEM_W-1:0]     lo_q;
    logic [ADDR_W-1:0]    dst_q;
    logic [ADDR_W-1:0]    src_q;
    logic [MEM_W-1:0]     wdata_q;
    logic [2*MEM_W-1:0]   rdata_q;
    logic                 accept;

    assign accept       = req_valid && req_ready;
    assign req_ready    = (state_q == IDLE) && !rst;
    assign resp_valid   = (state_q == RESP) && !rst;
    assign mem_write    = ((state_q == WR_LO) || (state_q == WR_HI)) && !rst;
    assign mem_dst_addr = dst_q;
    assign mem_src_addr = src_q;
    assign mem_wdata    = wdata_q;
    assign resp_rdata   = rdata_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = req_write ? WR_LO : RD_LO;
            WR_LO:   state_d = wide_q ? WR_HI : RESP;
            WR_HI:   state_d = RESP;
            RD_LO:   state_d = wide_q ? RD_HI : RD_WAIT;
            RD_HI:   state_d = RD_WAIT;
            RD_WAIT: state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat registers are loaded one edge ahead so each state drives them directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wide_q  <= 1'b0;
            whi_q   <= '0;
            lo_q    <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wide_q <= req_wide;
                        if (req_write) begin
                            dst_q   <= req_addr;
                            wdata_q <= req_wdata[MEM_W-1:0];
                            whi_q   <= req_wdata[2*MEM_W-1:MEM_W];
                        end else begin
                            src_q <= req_addr;
                        end
                    end
                end
                WR_LO: begin
                    if (wide_q) begin
                        dst_q   <= dst_q + ADDR_W'(1);
                        wdata_q <= whi_q;
                    end else begin
                        rdata_q <= '0;
                    end
                end
                WR_HI: rdata_q <= '0;
                RD_LO: if (wide_q) src_q <= src_q + ADDR_W'(1);
                RD_HI: lo_q <= mem_rdata;
                RD_WAIT: begin
                    rdata_q <= wide_q ? {mem_rdata, lo_q}
                                      : {{MEM_W{1'b0}}, mem_rdata};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a registered-read memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_wide;
    logic [20:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [20:0] mem_dst_addr;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic [20:0] mem_src_addr;
    logic [15:0] mem_rdata;

    int pass_cnt = 0;
    int total    = 0;

    logic [15:0] mem [logic [20:0]];

    int          lat;
    int          busy_ready;
    logic        ready_after;
    logic [31:0] rd;
    int          nwr;
    int          wc [4];
    logic [20:0] wa [4];
    logic [15:0] wdv [4];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(21), .MEM_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_wide     (req_wide),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .mem_dst_addr (mem_dst_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_src_addr (mem_src_addr),
        .mem_rdata    (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_write) mem[mem_dst_addr] = mem_wdata;
        mem_rdata <= mem.exists(mem_src_addr) ? mem[mem_src_addr] : 16'h0;
    end

    task automatic send(input logic w, input logic wide,
                        input logic [20:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_wide  = wide;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
    endtask

    task automatic collect(input int max, input bit keep);
        bit got = 0;
        bit ra_set = 0;
        lat = 0;
        busy_ready = 0;
        ready_after = 1'b0;
        rd = 32'hx;
        nwr = 0;
        for (int c = 1; c <= max; c++) begin
            @(negedge clk);
            if (mem_write && nwr < 4) begin
                wc[nwr]  = c;
                wa[nwr]  = mem_dst_addr;
                wdv[nwr] = mem_wdata;
                nwr++;
            end
            if (!got && req_ready) busy_ready++;
            if (resp_valid && !got) begin
                got = 1;
                lat = c;
                rd  = resp_rdata;
            end else if (got && !ra_set) begin
                ready_after = req_ready;
                ra_set = 1;
            end
            if (!keep || (got && c > lat)) req_valid = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wide  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", req_ready);
        else pass_cnt++;
        total++;
        if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid);
        else pass_cnt++;
        total++;
        if (resp_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", resp_rdata);
        else pass_cnt++;
        total++;
        if (mem_write !== 1'b0) $display("FAIL rst_mem_write got %b want 0", mem_write);
        else pass_cnt++;
        total++;
        if (mem_dst_addr !== 21'h0 || mem_src_addr !== 21'h0)
            $display("FAIL rst_addr got dst=%h src=%h want 0", mem_dst_addr, mem_src_addr);
        else pass_cnt++;
        total++;
        if (mem_wdata !== 16'h0) $display("FAIL rst_wdata got %h want 0", mem_wdata);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", req_ready);
        else pass_cnt++;
    endtask

    task automatic test_store16;
        total++;
        if (req_ready !== 1'b1) $display("FAIL st16_ready got %b want 1", req_ready);
        else pass_cnt++;
        send(1'b1, 1'b0, 21'h00010, 32'h0000BEEF);
        collect(6, 1'b0);
        total++;
        if (nwr !== 1 || wc[0] !== 1)
            $display("FAIL st16_beats got n=%0d c=%0d want n=1 c=1", nwr, wc[0]);
        else pass_cnt++;
        total++;
        if (wa[0] !== 21'h00010 || wdv[0] !== 16'hBEEF)
            $display("FAIL st16_beat got %h@%h want beef@00010", wdv[0], wa[0]);
        else pass_cnt++;
        total++;
        if (lat !== 2) $display("FAIL st16_latency got %0d want 2", lat);
        else pass_cnt++;
        total++;
        if (rd !== 32'h0) $display("FAIL st16_rdata got %h want 0", rd);
        else pass_cnt++;
    endtask

    task automatic test_store32_wrap;
        send(1'b1, 1'b1, 21'h1FFFFF, 32'h12345678);
        collect(6, 1'b0);
        total++;
        if (nwr !== 2 || wc[0] !== 1 || wc[1] !== 2)
            $display("FAIL st32_beats got n=%0d c0=%0d c1=%0d want 2,1,2", nwr, wc[0], wc[1]);
        else pass_cnt++;
        total++;
        if (wa[0] !== 21'h1FFFFF || wdv[0] !== 16'h5678)
            $display("FAIL st32_lo got %h@%h want 5678@1fffff", wdv[0], wa[0]);
        else pass_cnt++;
        total++;
        if (wa[1] !== 21'h000000 || wdv[1] !== 16'h1234)
            $display("FAIL st32_hi got %h@%h want 1234@000000", wdv[1], wa[1]);
        else pass_cnt++;
        total++;
        if (lat !== 3) $display("FAIL st32_latency got %0d want 3", lat);
        else pass_cnt++;
    endtask

    task automatic test_load32_wrap;
        send(1'b0, 1'b1, 21'h1FFFFF, 32'hFFFFFFFF);
        collect(7, 1'b0);
        total++;
        if (lat !== 4) $display("FAIL ld32_latency got %0d want 4", lat);
        else pass_cnt++;
        total++;
        if (rd !== 32'h12345678) $display("FAIL ld32_rdata got %h want 12345678", rd);
        else pass_cnt++;
        total++;
        if (nwr !== 0) $display("FAIL ld32_no_write got %0d writes want 0", nwr);
        else pass_cnt++;
        total++;
        if (resp_rdata !== 32'h12345678)
            $display("FAIL ld32_hold got %h want 12345678", resp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_load16_held;
        send(1'b0, 1'b0, 21'h00010, 32'h0);
        collect(6, 1'b1);
        total++;
        if (lat !== 3) $display("FAIL ld16_latency got %0d want 3", lat);
        else pass_cnt++;
        total++;
        if (rd !== 32'h0000BEEF) $display("FAIL ld16_rdata got %h want 0000beef", rd);
        else pass_cnt++;
        total++;
        if (busy_ready !== 0) $display("FAIL ld16_busy_ready got %0d want 0", busy_ready);
        else pass_cnt++;
        total++;
        if (ready_after !== 1'b1) $display("FAIL ld16_ready_after got %b want 1", ready_after);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        bit found = 0;
        send(1'b1, 1'b0, 21'h00020, 32'h0000CAFE);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                found = 1;
                break;
            end
        end
        total++;
        if (!found) $display("FAIL b2b_store_resp got none want pulse");
        else pass_cnt++;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_wide  = 1'b0;
        req_addr  = 21'h00020;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) $display("FAIL b2b_idle_ready got %b want 1", req_ready);
        else pass_cnt++;
        @(posedge clk);
        collect(6, 1'b0);
        total++;
        if (lat !== 3 || rd !== 32'h0000CAFE)
            $display("FAIL b2b_load got lat=%0d rd=%h want 3 0000cafe", lat, rd);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_store;
        int stray = 0;
        send(1'b1, 1'b1, 21'h00030, 32'hAAAA5555);
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (mem_write !== 1'b1 || mem_dst_addr !== 21'h00030)
            $display("FAIL rmid_lo got we=%b dst=%h want 1 00030", mem_write, mem_dst_addr);
        else pass_cnt++;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if (mem_write !== 1'b0) $display("FAIL rmid_we got %b want 0", mem_write);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        total++;
        if (stray !== 0) $display("FAIL rmid_resp got %0d pulses want 0", stray);
        else pass_cnt++;
        total++;
        if (mem.exists(21'h00031))
            $display("FAIL rmid_hi_word got %h want unwritten", mem[21'h00031]);
        else pass_cnt++;
        total++;
        if (!mem.exists(21'h00030) || mem[21'h00030] !== 16'h5555)
            $display("FAIL rmid_lo_word got missing/other want 5555");
        else pass_cnt++;
        total++;
        if (req_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", req_ready);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_store16();
        test_store32_wrap();
        test_load32_wrap();
        test_load16_held();
        test_back_to_back();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
